// File: rtl/btn_pkg.sv
// Shared timing constants and constant-function helpers for the push-button conditioner.
// Default timings assume a 50 MHz system clock.
package btn_pkg;

    localparam int DB_10MS   = 500000;
    localparam int LONG_1S   = 50000000;
    localparam int REP_200MS = 10000000;

    // Smallest r with 2**r >= v.
    function automatic int clog2(input longint unsigned v);
        int r;
        r = 0;
        while ((64'd1 << r) < v) begin
            r++;
        end
        return r;
    endfunction

    function automatic longint unsigned max_u(input longint unsigned a, input longint unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/debounce_chan.sv
// One button channel: 2-FF synchroniser, strict stable-time debouncer, edge strobes,
// long-press detection and optional auto-repeat.
module debounce_chan
    import btn_pkg::*;
#(
    parameter int DB_CYCLES     = DB_10MS,
    parameter int LONG_CYCLES   = LONG_1S,
    parameter int REPEAT_CYCLES = 0,
    parameter bit ACTIVE_LOW    = 1'b1
) (
    input  logic clk,
    input  logic n_reset,
    input  logic i_btn,
    output logic o_db,
    output logic o_rise,
    output logic o_fall,
    output logic o_long,
    output logic o_rep
);

    localparam int DW = clog2(longint'(DB_CYCLES) + 1);
    localparam int HW = clog2(max_u(longint'(LONG_CYCLES), longint'(REPEAT_CYCLES)) + 1);
    localparam int RW = (REPEAT_CYCLES > 0) ? clog2(longint'(REPEAT_CYCLES) + 1) : 1;
    localparam bit REP_EN = (REPEAT_CYCLES > 0);

    localparam logic [DW-1:0] D_LAST = DW'(DB_CYCLES - 1);
    localparam logic [DW-1:0] D_ONE  = DW'(1);
    localparam logic [HW-1:0] L_LAST = HW'(LONG_CYCLES - 1);
    localparam logic [HW-1:0] L_SAT  = HW'(LONG_CYCLES);
    localparam logic [HW-1:0] H_ONE  = HW'(1);
    localparam logic [RW-1:0] R_LAST = RW'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);
    localparam logic [RW-1:0] R_ONE  = RW'(1);

    logic          r_s1;
    logic          r_s2;
    logic [DW-1:0] r_dcnt;
    logic          r_db;
    logic          r_rise;
    logic          r_fall;
    logic [HW-1:0] r_hcnt;
    logic          r_long_done;
    logic [RW-1:0] r_rcnt;
    logic          r_long;
    logic          r_rep;

    logic w_change;
    logic w_fall_now;
    logic w_long_hit;
    logic w_rep_hit;

    assign w_change   = (r_s2 != r_db) && (r_dcnt == D_LAST);
    assign w_fall_now = w_change && r_db;
    // A release landing on a threshold edge swallows the long/repeat strobe.
    assign w_long_hit = r_db && !r_long_done && (r_hcnt == L_LAST) && !w_fall_now;
    assign w_rep_hit  = REP_EN && r_db && r_long_done && (r_rcnt == R_LAST) && !w_fall_now;

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_dcnt <= '0;
            r_db   <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_s1   <= i_btn ^ ACTIVE_LOW;
            r_s2   <= r_s1;
            r_rise <= w_change && !r_db;
            r_fall <= w_fall_now;
            if (r_s2 == r_db) begin
                r_dcnt <= '0;
            end else if (r_dcnt == D_LAST) begin
                r_db   <= r_s2;
                r_dcnt <= '0;
            end else begin
                r_dcnt <= r_dcnt + D_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            r_hcnt      <= '0;
            r_long_done <= 1'b0;
            r_rcnt      <= '0;
            r_long      <= 1'b0;
            r_rep       <= 1'b0;
        end else begin
            r_long <= w_long_hit;
            r_rep  <= w_rep_hit;
            if (!r_db || w_fall_now) begin
                r_hcnt      <= '0;
                r_long_done <= 1'b0;
                r_rcnt      <= '0;
            end else begin
                if (r_hcnt != L_SAT) begin
                    r_hcnt <= r_hcnt + H_ONE;
                end
                if (w_long_hit) begin
                    r_long_done <= 1'b1;
                end
                // Repeat phase starts counting the edge after long_pulse.
                if (REP_EN && r_long_done) begin
                    if (r_rcnt == R_LAST) begin
                        r_rcnt <= '0;
                    end else begin
                        r_rcnt <= r_rcnt + R_ONE;
                    end
                end
            end
        end
    end

    assign o_db   = r_db;
    assign o_rise = r_rise;
    assign o_fall = r_fall;
    assign o_long = r_long;
    assign o_rep  = r_rep;

endmodule

// File: rtl/btn_debounce_multi.sv
// Multi-channel front-panel button conditioner; each channel is an independent debounce_chan.
// db_out is 1 while a button is held, regardless of pin polarity.
module btn_debounce_multi
    import btn_pkg::*;
#(
    parameter int CH            = 4,
    parameter int DB_CYCLES     = DB_10MS,
    parameter int LONG_CYCLES   = LONG_1S,
    parameter int REPEAT_CYCLES = 0,
    parameter bit ACTIVE_LOW    = 1'b1
) (
    input  logic          clk,
    input  logic          n_reset,
    input  logic [CH-1:0] btn_in,
    output logic [CH-1:0] db_out,
    output logic [CH-1:0] rise_pulse,
    output logic [CH-1:0] fall_pulse,
    output logic [CH-1:0] long_pulse,
    output logic [CH-1:0] rep_pulse
);

    for (genvar g = 0; g < CH; g++) begin : g_chan
        debounce_chan #(
            .DB_CYCLES    (DB_CYCLES),
            .LONG_CYCLES  (LONG_CYCLES),
            .REPEAT_CYCLES(REPEAT_CYCLES),
            .ACTIVE_LOW   (ACTIVE_LOW)
        ) u_chan (
            .clk    (clk),
            .n_reset(n_reset),
            .i_btn  (btn_in[g]),
            .o_db   (db_out[g]),
            .o_rise (rise_pulse[g]),
            .o_fall (fall_pulse[g]),
            .o_long (long_pulse[g]),
            .o_rep  (rep_pulse[g])
        );
    end

endmodule

// File: tb/tb_btn_debounce_multi.sv
// Directed bench: two-channel active-low build with repeat, plus a one-channel
// active-high build without repeat; edges are counted from the last reset or window start.
module tb_btn_debounce_multi;

    localparam int REP = 3;

    logic       clk = 1'b0;
    logic       n_reset = 1'b0;
    logic [1:0] btn_a = 2'b00;
    logic [1:0] db_a, rise_a, fall_a, long_a, rep_a;
    logic [0:0] btn_b = 1'b0;
    logic [0:0] db_b, rise_b, fall_b, long_b, rep_b;

    int n_assert = 0;
    int n_fail   = 0;
    int long_cnt;
    int rep_cnt;

    always #5 clk = ~clk;

    btn_debounce_multi #(
        .CH(2), .DB_CYCLES(4), .LONG_CYCLES(10), .REPEAT_CYCLES(REP), .ACTIVE_LOW(1'b1)
    ) dut_a (
        .clk(clk), .n_reset(n_reset), .btn_in(btn_a),
        .db_out(db_a), .rise_pulse(rise_a), .fall_pulse(fall_a),
        .long_pulse(long_a), .rep_pulse(rep_a)
    );

    btn_debounce_multi #(
        .CH(1), .DB_CYCLES(4), .LONG_CYCLES(10), .REPEAT_CYCLES(0), .ACTIVE_LOW(1'b0)
    ) dut_b (
        .clk(clk), .n_reset(n_reset), .btn_in(btn_b),
        .db_out(db_b), .rise_pulse(rise_b), .fall_pulse(fall_b),
        .long_pulse(long_b), .rep_pulse(rep_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " db"},   32'(db_a),   32'd0);
        chk({tag, " rise"}, 32'(rise_a), 32'd0);
        chk({tag, " fall"}, 32'(fall_a), 32'd0);
        chk({tag, " long"}, 32'(long_a), 32'd0);
        chk({tag, " rep"},  32'(rep_a),  32'd0);
        chk({tag, " b"},    32'({db_b, rise_b, fall_b, long_b, rep_b}), 32'd0);
    endtask

    // pat[i] = pressed level sampled at window edge i; t_* < 0 means the event must not occur.
    task automatic run_ch(input string tag, input int ch, input int n, input logic [63:0] pat,
                          input logic db0, input int t_rise, input int t_fall, input int t_long,
                          input int t_rep0, input int t_replast);
        logic       e_db;
        logic       e_rep;
        logic [4:0] oth;
        int         oc;
        e_db = db0;
        oc   = 1 - ch;
        for (int i = 1; i <= n; i++) begin
            btn_a[ch] = ~pat[i];
            tick();
            if (i == t_rise) e_db = 1'b1;
            if (i == t_fall) e_db = 1'b0;
            e_rep = (t_rep0 > 0) && (i >= t_rep0) && (i <= t_replast) && ((i - t_rep0) % REP == 0);
            chk($sformatf("%s e%0d db", tag, i),   32'(db_a[ch]),   32'(e_db));
            chk($sformatf("%s e%0d rise", tag, i), 32'(rise_a[ch]), 32'(i == t_rise));
            chk($sformatf("%s e%0d fall", tag, i), 32'(fall_a[ch]), 32'(i == t_fall));
            chk($sformatf("%s e%0d long", tag, i), 32'(long_a[ch]), 32'(i == t_long));
            chk($sformatf("%s e%0d rep", tag, i),  32'(rep_a[ch]),  32'(e_rep));
            oth = {db_a[oc], rise_a[oc], fall_a[oc], long_a[oc], rep_a[oc]};
            chk($sformatf("%s e%0d other", tag, i), 32'(oth), 32'd0);
        end
    endtask

    initial begin
        // 1: reset with both buttons pressed, then both accepted together and released.
        n_reset = 1'b0;
        btn_a   = 2'b00;
        btn_b   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_all_zero($sformatf("t1 rst%0d", i));
        end
        n_reset = 1'b1;
        for (int e = 1; e <= 15; e++) begin
            tick();
            chk($sformatf("t1 e%0d db", e),   32'(db_a),   32'((e >= 6 && e < 13) ? 3 : 0));
            chk($sformatf("t1 e%0d rise", e), 32'(rise_a), 32'((e == 6) ? 3 : 0));
            chk($sformatf("t1 e%0d fall", e), 32'(fall_a), 32'((e == 13) ? 3 : 0));
            chk($sformatf("t1 e%0d long", e), 32'(long_a), 32'd0);
            if (e == 7) btn_a = 2'b11;
        end
        chk("t1 b idle db", 32'(db_b), 32'd0);

        // 2: ch0 clean press; repeat due at edge 31 coincides with the release and is dropped.
        run_ch("t2", 0, 40, 64'h0000_0000_03FF_FFFE, 1'b0, 6, 31, 16, 19, 28);

        // 3: ch0 bounce (3 pressed, 1 released, then held) accepted only after 4 stable samples.
        run_ch("t3", 0, 22, 64'h0000_0000_0000_0FEE, 1'b0, 10, 17, -1, -1, -1);

        // 4: ch1 release lands on the long threshold edge; fall wins.
        run_ch("t4", 1, 25, 64'h0000_0000_0000_07FE, 1'b0, 6, 16, -1, -1, -1);

        // 5: reset while held past long press, then restart with the button still held.
        run_ch("t5a", 0, 20, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 6, -1, 16, 19, 19);
        n_reset = 1'b0;
        tick();
        chk_all_zero("t5 rst0");
        tick();
        chk_all_zero("t5 rst1");
        n_reset = 1'b1;
        run_ch("t5b", 0, 24, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 6, -1, 16, 19, 22);
        btn_a = 2'b11;

        // 6: active-high build without repeat, held for 30 samples.
        long_cnt = 0;
        rep_cnt  = 0;
        for (int i = 1; i <= 40; i++) begin
            btn_b = (i <= 30) ? 1'b1 : 1'b0;
            tick();
            if (long_b[0]) long_cnt++;
            if (rep_b[0])  rep_cnt++;
            if (i == 5)  chk("t6 db before accept", 32'(db_b), 32'd0);
            if (i == 6)  chk("t6 rise", 32'({db_b, rise_b}), 32'b11);
            if (i == 16) chk("t6 long edge", 32'(long_b), 32'd1);
            if (i == 36) chk("t6 fall", 32'({db_b, fall_b}), 32'b01);
        end
        chk("t6 long count", 32'(long_cnt), 32'd1);
        chk("t6 rep count",  32'(rep_cnt),  32'd0);
        chk("t6 db final",   32'(db_b),     32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/btn_debounce_multi.md
Name: btn_debounce_multi

Overview:
Parametrised multi-channel push-button conditioner for front-panel buttons and switches. Each channel has:
- a 2-FF synchroniser
- a strict stable-time debouncer, with a configurable cycle count instead of a power-of-two MSB
- polarity normalisation
- one-cycle press/release strobes
- long-press detection with optional auto-repeat

It sits between the FPGA button pins and the control FSMs.

Parameters:
CH, 4, number of independent channels
DB_CYCLES, 500000, consecutive stable samples required to accept a new level (10 ms at 50 MHz); legal range >= 1
LONG_CYCLES, 50000000, cycles db_out must stay 1 before long_pulse fires (1 s); legal range >= 1
REPEAT_CYCLES, 0, auto-repeat period after a long press; 0 disables repeat
ACTIVE_LOW, 1, 1 = pin reads 0 when pressed; input is inverted before synchronising

Ports:
clk  in  1  system clock
n_reset  in  1  synchronous, active-low reset
btn_in  in  CH  raw asynchronous button pins
db_out  out  CH  debounced level, 1 = pressed
rise_pulse  out  CH  1-cycle strobe when db_out goes 0->1
fall_pulse  out  CH  1-cycle strobe when db_out goes 1->0
long_pulse  out  CH  1-cycle strobe when a press reaches LONG_CYCLES
rep_pulse  out  CH  1-cycle auto-repeat strobe while held past the long threshold

Behaviour:
- Reset and clocking
  - Clock is clk. Reset is n_reset: synchronous, active-low.
  - On a reset edge, all registers clear: sync FFs, counters, db_out, and all pulses go to 0. Reset mid-press therefore reads as released, and no fall_pulse is generated.
- Synchronisation and polarity
  - Per channel, n = btn_in ^ ACTIVE_LOW.
  - s1 <= n; s2 <= s1.
- Debounce (per channel)
  - Counter dcnt has width $clog2(DB_CYCLES+1).
  - If s2 == db_out: dcnt <= 0.
  - Else, if dcnt == DB_CYCLES-1: db_out <= s2 and dcnt <= 0.
  - Otherwise dcnt <= dcnt+1.
  - Any sample equal to db_out restarts the count, so a glitch shorter than DB_CYCLES never propagates.
  - Latency: btn_in change sampled at edge k -> db_out changes at edge k+1+DB_CYCLES.
- Strobes
  - rise_pulse and fall_pulse are registered on the same edge db_out changes, and are high for exactly one cycle.
- Hold timer
  - Counter hcnt is saturating, width $clog2(max(LONG_CYCLES, REPEAT_CYCLES)+1).
  - It is 0 while db_out == 0 and increments each cycle db_out == 1.
  - State flag long_done is set on the edge long_pulse fires.
  - On the edge db_out goes 1->0, hcnt, long_done and the repeat counter clear.
- Long pulse
  - long_pulse fires on the edge where hcnt reaches LONG_CYCLES, i.e. LONG_CYCLES edges after rise_pulse.
  - It fires once per press.
- Auto-repeat
  - Active only if REPEAT_CYCLES > 0 and long_done == 1.
  - Counter rcnt counts; rep_pulse fires every REPEAT_CYCLES edges after long_pulse, then rcnt wraps to 0.
- Simultaneous events
  - If the release edge (db_out 1->0) coincides with a long or repeat threshold, fall_pulse wins and long_pulse/rep_pulse are suppressed.
  - long_pulse and rep_pulse are never high in the same cycle.
- Channel independence
  - Channels share no state; simultaneous activity on all channels behaves identically to isolated activity.
- Width rule
  - All counters compare with ==, never with an MSB test, so non-power-of-two counts are exact.

Decomposition:
- Shared package btn_pkg holds:
  - default timing constants at 50 MHz: DB_10MS = 500000, LONG_1S = 50000000, REP_200MS = 10000000
  - a clog2 helper
- Sub-module debounce_chan contains one channel: sync, debounce, strobes, hold, repeat.
- The top level instantiates debounce_chan CH times with generate and passes all parameters through.

Test Plan (CH=2, DB_CYCLES=4, LONG_CYCLES=10, REPEAT_CYCLES=3, ACTIVE_LOW=1):
1. Hold n_reset=0 for 3 cycles with btn_in=2'b00 (both pressed) -> db_out=0 and all pulses 0 during reset; release reset at edge 0 -> db_out[1:0]=2'b11 at edge 6; rise_pulse=2'b11 for 1 cycle only.
2. ch0 clean press (btn_in[0] 1->0 before edge 1) -> db_out[0]=1 at edge 6 with rise_pulse; long_pulse at edge 16; rep_pulse at edges 19, 22, 25; release -> fall_pulse 5 edges after the release sample; no further rep_pulse.
3. ch0 bounce: pressed 3 cycles, released 1, pressed 3 -> db_out stays 0 and no rise_pulse; then held 4 stable samples -> db_out=1.
4. ch1 pressed with release timed so db_out falls on the same edge hcnt reaches 10 -> fall_pulse=1, long_pulse=0; ch0 idle throughout with no pulses.
5. Assert n_reset=0 mid-hold after long_pulse -> next edge all outputs 0, no fall_pulse; deassert with the button still pressed -> fresh rise_pulse after 5 edges and long_pulse 10 edges later.
6. REPEAT_CYCLES=0 and ACTIVE_LOW=0 build: active-high press held for 30 cycles -> exactly one long_pulse, zero rep_pulse.
